// File: rtl/wishbone_response_slice_if.sv
// rggen_wishbone_if: Wishbone B4 bus bundle.
// Master drives the request side; slave drives stall and the response.
interface rggen_wishbone_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cyc;
  logic                stb;
  logic                stall;
  logic [ADDR_W-1:0]   adr;
  logic                we;
  logic [DATA_W-1:0]   dat_w;
  logic [DATA_W/8-1:0] sel;
  logic                ack;
  logic                err;
  logic                rty;
  logic [DATA_W-1:0]   dat_r;

  modport master (
    output cyc,
    output stb,
    output adr,
    output we,
    output dat_w,
    output sel,
    input  stall,
    input  ack,
    input  err,
    input  rty,
    input  dat_r
  );

  modport slave (
    input  cyc,
    input  stb,
    input  adr,
    input  we,
    input  dat_w,
    input  sel,
    output stall,
    output ack,
    output err,
    output rty,
    output dat_r
  );
endinterface

// File: rtl/wishbone_response_slice.sv
// wishbone_response_slice: registered single-outstanding Wishbone slice.
// Define WISHBONE_RESPONSE_SLICE_TIMEOUT_EN to add the response timeout.
module wishbone_response_slice #(
  parameter bit          DOWNSTREAM_USE_STALL = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES       = 255,
  parameter int          ADDR_W               = 32,
  parameter int          DATA_W               = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rggen_wishbone_if.slave  slave_if,
  rggen_wishbone_if.master master_if
);
  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic              we;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
  } req_t;

  typedef struct packed {
    logic err;
    logic rty;
    logic ack;
  } sts_t;

  state_t            state_q;
  state_t            state_d;
  req_t              req_q;
  sts_t              sts_q;
  sts_t              sts_d;
  logic [DATA_W-1:0] rdat_q;
  logic [DATA_W-1:0] rdat_d;
  logic              cyc_q;
  logic              stb_q;
  logic              stall_q;

  logic accepted;
  logic resp_in;
  logic abort;
  logic expired;
  logic take_resp;
  logic timeout;
  logic load_req;

  assign accepted = !DOWNSTREAM_USE_STALL
                 || !master_if.stall;
  assign resp_in  = master_if.ack
                 || master_if.err
                 || master_if.rty;
  assign abort    = !slave_if.cyc;
  assign load_req = (state_q == IDLE)
                 && (state_d == ISSUE);

`ifdef WISHBONE_RESPONSE_SLICE_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        busy;

  assign busy = (state_q == ISSUE)
             || (state_q == WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
    end else if (load_req) begin
      tmo_cnt_q <= '0;
    end else if (busy) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign expired = busy
    && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
`else
  localparam int unsigned unused_tmo = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  // Abort beats a response; a response beats expiry.
  always_comb begin
    state_d   = state_q;
    take_resp = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slave_if.cyc && slave_if.stb) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accepted && resp_in) begin
          state_d   = RESP;
          take_resp = 1'b1;
        end else if (expired) begin
          state_d = RESP;
          timeout = 1'b1;
        end else if (accepted) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (resp_in) begin
          state_d   = RESP;
          take_resp = 1'b1;
        end else if (expired) begin
          state_d = RESP;
          timeout = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    sts_d  = '0;
    rdat_d = '0;
    if (timeout) begin
      sts_d.err = 1'b1;
    end else if (take_resp) begin
      if (master_if.err) begin
        sts_d.err = 1'b1;
      end else if (master_if.rty) begin
        sts_d.rty = 1'b1;
      end else begin
        sts_d.ack = 1'b1;
        if (!req_q.we) begin
          rdat_d = master_if.dat_r;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      stall_q <= 1'b0;
      sts_q   <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= (state_d == ISSUE)
              || (state_d == WAIT);
      stb_q   <= (state_d == ISSUE);
      stall_q <= (state_d != IDLE);
      sts_q   <= sts_d;
      rdat_q  <= rdat_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q <= '0;
    end else if (load_req) begin
      req_q.adr <= slave_if.adr;
      req_q.we  <= slave_if.we;
      req_q.dat <= slave_if.dat_w;
      req_q.sel <= slave_if.sel;
    end
  end

  assign master_if.cyc   = cyc_q;
  assign master_if.stb   = stb_q;
  assign master_if.adr   = req_q.adr;
  assign master_if.we    = req_q.we;
  assign master_if.dat_w = req_q.dat;
  assign master_if.sel   = req_q.sel;

  assign slave_if.stall = stall_q;
  assign slave_if.ack   = sts_q.ack;
  assign slave_if.err   = sts_q.err;
  assign slave_if.rty   = sts_q.rty;
  assign slave_if.dat_r = rdat_q;
endmodule

// File: tb/tb_wishbone_response_slice.sv
// tb_wishbone_response_slice: scoreboard bench for the response slice.
// Expected status/data/latency are queued at issue, checked at response.
module tb_wishbone_response_slice;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rggen_wishbone_if #(.ADDR_W(32), .DATA_W(32)) up ();
  rggen_wishbone_if #(.ADDR_W(32), .DATA_W(32)) dn ();

  wishbone_response_slice #(
    .DOWNSTREAM_USE_STALL (1'b1),
    .TIMEOUT_CYCLES       (8),
    .ADDR_W               (32),
    .DATA_W               (32)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .slave_if  (up),
    .master_if (dn)
  );

  typedef struct {
    logic [2:0]  sts;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic pulse();
    return up.ack | up.err | up.rty;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dn_quiet();
    dn.stall = 1'b0;
    dn.ack   = 1'b0;
    dn.err   = 1'b0;
    dn.rty   = 1'b0;
    dn.dat_r = '0;
  endtask

  task automatic up_quiet();
    up.cyc   = 1'b0;
    up.stb   = 1'b0;
    up.we    = 1'b0;
    up.adr   = '0;
    up.dat_w = '0;
    up.sel   = '0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if ({dn.cyc, dn.stb, dn.we} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_ctl got=%b exp=000", {dn.cyc, dn.stb, dn.we});
    end
    n_cmp++;
    if ({dn.adr, dn.dat_w, dn.sel} !== '0) begin
      n_bad++;
      $display("FAIL rst_fields got=%h/%h/%h exp=0", dn.adr, dn.dat_w, dn.sel);
    end
    n_cmp++;
    if ({up.ack, up.err, up.rty, up.stall} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_up got=%b exp=0000", {up.ack, up.err, up.rty, up.stall});
    end
    n_cmp++;
    if (up.dat_r !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_dat_r got=%h exp=0", up.dat_r);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({dn.cyc, up.stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_release got=%b exp=00", {dn.cyc, up.stall});
    end
  endtask

  // One transaction: nstall stall cycles in ISSUE, response presented
  // d cycles after the downstream acceptance cycle (0 = same cycle).
  task automatic test_txn(
    input string       nm,
    input logic        we,
    input logic [31:0] adr,
    input logic [31:0] wd,
    input logic [3:0]  sel,
    input int          nstall,
    input int          d,
    input logic        a,
    input logic        e,
    input logic        r,
    input logic [31:0] rd
  );
    exp_t x;
    exp_t g;
    int   k;
    int   stb_n;
    x.sts = e ? 3'b100 : (r ? 3'b010 : 3'b001);
    x.dat = (!e && !r && !we) ? rd : 32'h0;
    x.lat = nstall + d + 2;
    sb.push_back(x);
    dn_quiet();
    up.cyc   = 1'b1;
    up.stb   = 1'b1;
    up.we    = we;
    up.adr   = adr;
    up.dat_w = wd;
    up.sel   = sel;
    tick();
    up.stb = 1'b0;
    k      = 0;
    stb_n  = 0;
    while (!pulse() && k < 200) begin
      if (k == 0) begin
        n_cmp++;
        if ({dn.cyc, dn.stb, dn.we} !== {2'b11, we}) begin
          n_bad++;
          $display("FAIL %s issue_ctl got=%b exp=%b", nm, {dn.cyc, dn.stb, dn.we}, {2'b11, we});
        end
        n_cmp++;
        if (dn.adr !== adr || dn.dat_w !== wd || dn.sel !== sel) begin
          n_bad++;
          $display("FAIL %s issue_fields got=%h/%h/%h exp=%h/%h/%h", nm, dn.adr, dn.dat_w, dn.sel, adr, wd, sel);
        end
      end
      n_cmp++;
      if (up.stall !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy_stall k=%0d got=%b exp=1", nm, k, up.stall);
      end
      if (dn.stb) stb_n++;
      dn.stall = (k < nstall);
      if (k == nstall + d) begin
        {dn.ack, dn.err, dn.rty} = {a, e, r};
        dn.dat_r = rd;
      end else begin
        {dn.ack, dn.err, dn.rty} = 3'b000;
        dn.dat_r = 32'h0;
      end
      tick();
      k++;
    end
    dn_quiet();
    g = sb.pop_front();
    n_cmp++;
    if (k >= 200) begin
      n_bad++;
      $display("FAIL %s resp_timeout got=none exp=lat %0d", nm, g.lat);
    end else begin
      if (k + 1 !== g.lat) begin
        n_bad++;
        $display("FAIL %s latency got=%0d exp=%0d", nm, k + 1, g.lat);
      end
      n_cmp++;
      if ({up.err, up.rty, up.ack} !== g.sts) begin
        n_bad++;
        $display("FAIL %s status got=%b exp=%b", nm, {up.err, up.rty, up.ack}, g.sts);
      end
      n_cmp++;
      if (up.dat_r !== g.dat) begin
        n_bad++;
        $display("FAIL %s dat_r got=%h exp=%h", nm, up.dat_r, g.dat);
      end
      n_cmp++;
      if (stb_n !== nstall + 1) begin
        n_bad++;
        $display("FAIL %s stb_cycles got=%0d exp=%0d", nm, stb_n, nstall + 1);
      end
      n_cmp++;
      if ({up.stall, dn.cyc} !== 2'b10) begin
        n_bad++;
        $display("FAIL %s resp_state got=%b exp=10", nm, {up.stall, dn.cyc});
      end
    end
    up_quiet();
    tick();
    n_cmp++;
    if ({pulse(), up.stall, dn.cyc} !== 3'b000 || up.dat_r !== 32'h0) begin
      n_bad++;
      $display("FAIL %s after_resp got=%b/%h exp=000/0", nm, {pulse(), up.stall, dn.cyc}, up.dat_r);
    end
  endtask

  task automatic test_status_priority();
    logic [2:0] tbl [5];
    tbl[0] = 3'b110;
    tbl[1] = 3'b101;
    tbl[2] = 3'b011;
    tbl[3] = 3'b111;
    tbl[4] = 3'b001;
    for (int i = 0; i < 5; i++) begin
      test_txn($sformatf("prio%0d", i), 1'b0, 32'h100 + i, 32'h0, 4'hF, 0, 1, tbl[i][2], tbl[i][1], tbl[i][0], 32'hCAFE_F00D);
    end
    test_txn("wr_ack_dat0", 1'b1, 32'h104, 32'h1111_2222, 4'h5, 1, 2, 1'b1, 1'b0, 1'b0, 32'h7777_8888);
    test_txn("same_cycle", 1'b0, 32'h108, 32'h0, 4'hF, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0BAD_F00D);
    test_txn("stall_same", 1'b0, 32'h10C, 32'h0, 4'hF, 3, 0, 1'b1, 1'b0, 1'b0, 32'h1234_0000);
  endtask

  task automatic test_abort();
    int pulses;
    pulses = 0;
    dn_quiet();
    up.cyc = 1'b1;
    up.stb = 1'b1;
    up.adr = 32'h30;
    up.sel = 4'hF;
    tick();
    up.stb = 1'b0;
    tick();
    n_cmp++;
    if ({dn.cyc, dn.stb} !== 2'b10) begin
      n_bad++;
      $display("FAIL abort_wait got=%b exp=10", {dn.cyc, dn.stb});
    end
    up.cyc = 1'b0;
    tick();
    n_cmp++;
    if ({dn.cyc, up.stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_drop got=%b exp=00", {dn.cyc, up.stall});
    end
    dn.ack   = 1'b1;
    dn.dat_r = 32'h5555_AAAA;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) dn_quiet();
      if (pulse()) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL abort_pulses got=%0d exp=0", pulses);
    end
    test_txn("post_abort", 1'b1, 32'h34, 32'h0F0F_0F0F, 4'hF, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    exp_t g;
    int   k;
    int   pulses;
    dn_quiet();
    up.cyc = 1'b1;
    up.stb = 1'b1;
    up.adr = 32'h40;
    up.sel = 4'hF;
`ifdef WISHBONE_RESPONSE_SLICE_TIMEOUT_EN
    sb.push_back('{sts: 3'b100, dat: 32'h0, lat: 9});
    tick();
    up.stb = 1'b0;
    k = 0;
    while (!pulse() && k < 100) begin
      tick();
      k++;
    end
    g = sb.pop_front();
    n_cmp++;
    if (k !== g.lat) begin
      n_bad++;
      $display("FAIL tmo_latency got=%0d exp=%0d", k, g.lat);
    end
    n_cmp++;
    if ({up.err, up.rty, up.ack} !== g.sts || up.dat_r !== g.dat) begin
      n_bad++;
      $display("FAIL tmo_resp got=%b/%h exp=%b/%h", {up.err, up.rty, up.ack}, up.dat_r, g.sts, g.dat);
    end
    n_cmp++;
    if (dn.cyc !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_cyc_drop got=%b exp=0", dn.cyc);
    end
    up_quiet();
    tick();
    n_cmp++;
    if ({pulse(), up.stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL tmo_after got=%b exp=00", {pulse(), up.stall});
    end
    pulses = 0;
`else
    tick();
    up.stb = 1'b0;
    pulses = 0;
    for (k = 0; k < 100; k++) begin
      if (pulse()) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL hang_pulses got=%0d exp=0", pulses);
    end
    n_cmp++;
    if ({dn.cyc, up.stall} !== 2'b11) begin
      n_bad++;
      $display("FAIL hang_state got=%b exp=11", {dn.cyc, up.stall});
    end
    up_quiet();
    tick();
    tick();
    n_cmp++;
    if ({dn.cyc, up.stall} !== 2'b00) begin
      n_bad++;
      $display("FAIL hang_abort got=%b exp=00", {dn.cyc, up.stall});
    end
    g.lat = 0;
`endif
    test_txn("tmo_edge", 1'b0, 32'h44, 32'h0, 4'hF, 0, 8, 1'b1, 1'b0, 1'b0, 32'h600D_D00D);
  endtask

  task automatic test_reset_mid();
    int pulses;
    int cyc_seen;
    pulses   = 0;
    cyc_seen = 0;
    dn_quiet();
    dn.stall = 1'b1;
    up.cyc   = 1'b1;
    up.stb   = 1'b1;
    up.we    = 1'b1;
    up.adr   = 32'h50;
    up.dat_w = 32'hA5A5_A5A5;
    up.sel   = 4'h3;
    tick();
    up.stb = 1'b0;
    tick();
    n_cmp++;
    if (dn.stb !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_issue got=%b exp=1", dn.stb);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dn.cyc, dn.stb, dn.we, up.stall} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rmid_ctl got=%b exp=0000", {dn.cyc, dn.stb, dn.we, up.stall});
    end
    n_cmp++;
    if ({dn.adr, dn.dat_w, dn.sel, up.dat_r} !== '0) begin
      n_bad++;
      $display("FAIL rmid_fields got=%h/%h/%h/%h exp=0", dn.adr, dn.dat_w, dn.sel, up.dat_r);
    end
    up_quiet();
    dn_quiet();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (pulse()) pulses++;
      if (dn.cyc) cyc_seen++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0 || cyc_seen !== 0) begin
      n_bad++;
      $display("FAIL rmid_after got=%0d/%0d exp=0/0", pulses, cyc_seen);
    end
    test_txn("post_reset", 1'b0, 32'h54, 32'h0, 4'hF, 0, 1, 1'b1, 1'b0, 1'b0, 32'h1357_9BDF);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      test_txn($sformatf("b2b%0d", i), i[0], 32'h200 + 4 * i, $urandom, 4'hF, i % 3, 1 + (i % 2), 1'b1, 1'b0, (i == 3), $urandom);
    end
  endtask

  initial begin
    up_quiet();
    dn_quiet();
    test_reset();
    test_txn("write", 1'b1, 32'h10, 32'h1234_5678, 4'hF, 0, 1, 1'b1, 1'b0, 1'b0, 32'h0);
    test_txn("read_stall", 1'b0, 32'h20, 32'h0, 4'hF, 2, 1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
    test_status_priority();
    test_abort();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wishbone_response_slice.md
# wishbone_response_slice

Single-outstanding Wishbone register slice placed downstream of the APB-to-Wishbone bridge, in front of the register block's Wishbone slave port. It breaks all combinational paths between bridge and register block by registering the request and the response. It supports pipelined (stall) and classic slaves downstream. A compile-time option adds a response timeout that terminates hung accesses with an error.

## Interface
- DOWNSTREAM_USE_STALL, 1: 1 = honour `master_if.stall`; 0 = downstream request is taken as accepted on its first cycle.
- TIMEOUT_CYCLES, 255: cycles allowed between downstream request issue and response. Range 1..65535. Used only when the timeout option is compiled in.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset; asynchronous, active-low.
- slave_if  rggen_wishbone_if.slave  -  upstream port, driven by the bridge.
- master_if  rggen_wishbone_if.master  -  downstream port, drives the register block.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `slave_if.stall` = 0.
  - On `slave_if.cyc && slave_if.stb`, capture adr, we, dat_w and sel, then go to ISSUE.
- ISSUE:
  - `master_if.cyc` = 1 and `master_if.stb` = 1, with the captured fields.
  - Go to WAIT when `!master_if.stall`, or unconditionally when DOWNSTREAM_USE_STALL = 0.
- WAIT:
  - `master_if.cyc` = 1 and `master_if.stb` = 0.
  - On `ack || err || rty` from downstream:
    - capture status;
    - capture `dat_r` only for a read with ack, otherwise capture 0;
    - go to RESP.
  - A response arriving in ISSUE in the same cycle as acceptance is handled the same way: go straight to RESP.
- RESP:
  - Exactly one cycle of `slave_if.ack`, `err` or `rty`, with the registered `dat_r`.
  - `master_if.cyc` = 0. Return to IDLE.
- `slave_if.stall` = 1 in ISSUE, WAIT and RESP. A new request is never accepted while one is outstanding.
- Simultaneous downstream status bits: priority is err, then rty, then ack. Exactly one upstream status bit pulses.
- Upstream abort: `slave_if.cyc` falls in ISSUE or WAIT.
  - Drop `master_if.cyc/stb` on the next cycle.
  - Discard any response. Go to IDLE. No upstream status pulse.
- Downstream status outside ISSUE/WAIT is ignored.
- Reset mid-access: asynchronous return to IDLE; in-flight access discarded.

## Timing
- Reset values:
  - state IDLE;
  - all `master_if` outputs (cyc, stb, adr, we, dat_w, sel) = 0;
  - `slave_if.ack/err/rty` = 0, `slave_if.dat_r` = 0, `slave_if.stall` = 0.
- Upstream request accepted at edge T → `master_if.stb` high in cycle T+1.
- Downstream response in cycle N → upstream status pulse in cycle N+1.
- Minimum round trip with a zero-wait, non-stalling slave: accept at T, issue in T+1, downstream ack in T+2, upstream ack in T+3.
- Each downstream stall cycle adds one cycle in ISSUE.
- All outputs are driven from flops; no combinational path from `slave_if` to `master_if` or in reverse.

## Configuration
- Macro: WISHBONE_RESPONSE_SLICE_TIMEOUT_EN.
- Defined:
  - 16-bit counter cleared on entry to ISSUE, incrementing each cycle in ISSUE and WAIT.
  - Counter reaching TIMEOUT_CYCLES with no response: drop `master_if.cyc/stb` next cycle and enter RESP with `err` = 1 and `dat_r` = 0.
  - A response in the same cycle as expiry takes precedence over the timeout.
- Undefined:
  - No counter logic.
  - The slice waits indefinitely in ISSUE/WAIT.
  - TIMEOUT_CYCLES is ignored.

## Test plan
- Write adr=0x10, dat_w=0x1234_5678, sel=0xF; slave acks one cycle after accept, no stall → `master_if` carries identical fields; upstream ack exactly 3 cycles after accept; stall=1 for those cycles.
- Read adr=0x20 with 2 cycles of downstream stall, slave returns 0xDEAD_BEEF with ack → `master_if.stb` held for 3 cycles; upstream `dat_r` = 0xDEAD_BEEF with a single-cycle ack.
- Downstream asserts ack and err in the same cycle on a read → upstream err=1, ack=0, `dat_r` = 0.
- Upstream `cyc` dropped during WAIT, slave acks later → no upstream pulse; `master_if.cyc` low the cycle after the drop; next request accepted normally.
- With macro defined and TIMEOUT_CYCLES = 8, slave never responds → upstream err=1 with `dat_r` = 0 exactly 9 cycles after `master_if.stb` first rises. Without the macro → no response after 100 cycles.
- `i_rst_n` pulsed low during ISSUE → all outputs 0 immediately; state IDLE; no upstream pulse after release.
